mcdf_arbiter: RTL and testbench
===============================

// Module: mcdf_arbiter
// PURPOSE
//  Packet-level round-robin arbiter and sequencer between the per-channel slave FIFOs and the MCDF formatter output.
//  - Grants one enabled channel at a time, but only when that channel's FIFO holds a full packet.
//  - Pops the FIFO beat by beat and drives the formatter stream (fmt_valid/fmt_ready, fmt_first/fmt_last).
//  - Tags every packet with its channel id and length.
// PARAMETERS
//  CH_NUM   4   number of channels (matches width of chnl_en)
//  CH_W     2   channel id width, = clog2(CH_NUM)
//  CNT_W    6   FIFO fill-count width (depth up to 32)
//  DATA_W   32  channel/formatter data width
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous reset, active-high
//  chnl_en    in   CH_NUM        per-channel enable
//  pkt_len    in   2*CH_NUM      per-channel length code {ch3..ch0}: 0->4, 1->8, 2->16, 3->32 beats
//  ch_cnt     in   CH_NUM*CNT_W  per-channel FIFO fill level
//  ch_data    in   CH_NUM*DATA_W per-channel FIFO head word (first-word-fall-through)
//  ch_rd      out  CH_NUM        per-channel FIFO pop, one-hot or zero
//  fmt_valid  out  1             formatter beat valid
//  fmt_ready  in   1             formatter accepts beat
//  fmt_data   out  DATA_W        beat data
//  fmt_first  out  1             first beat of packet
//  fmt_last   out  1             last beat of packet
//  fmt_chid   out  CH_W          channel id of current packet
//  fmt_len    out  CNT_W         beat count of current packet (4..32)
//  busy       out  1             high whenever state != IDLE
// BEHAVIOUR
//  Reset
//   - rst sampled at posedge clk; all outputs reset to 0.
//   - State reset to IDLE; rr_ptr reset to 0.
//   - rst mid-packet aborts the packet immediately; the FIFO keeps any words not yet popped.
//  Eligibility
//   - ch i is eligible iff chnl_en[i] && ch_cnt[i] >= len(pkt_len[i]).
//   - Comparison is unsigned in CNT_W bits.
//  FSM: IDLE, SEND
//   - IDLE, any channel eligible:
//     - Grant the first eligible channel searching upward from rr_ptr, wrapping mod CH_NUM.
//     - Latch grant into fmt_chid, decoded length into fmt_len and beats_left.
//     - rr_ptr <= (grant+1) mod CH_NUM.
//     - Next state SEND.
//   - IDLE, none eligible: stay in IDLE.
//   - SEND, load condition: beats_left>0 && (!fmt_valid || fmt_ready).
//     - Combinational outputs: ch_rd[grant]=1.
//     - Registered at the edge: fmt_data<=ch_data[grant], fmt_valid<=1, fmt_first<=(beats_left==fmt_len), fmt_last<=(beats_left==1).
//     - beats_left decrements.
//   - SEND, fmt_valid && !fmt_ready: hold fmt_valid, fmt_data, fmt_first and fmt_last; no pop.
//   - SEND, fmt_valid && fmt_ready && fmt_last:
//     - fmt_valid<=0, fmt_first<=0, fmt_last<=0.
//     - Next state IDLE.
//   - SEND, fmt_valid && fmt_ready && beats_left==0 && !fmt_last: cannot occur.
//  Output rules
//   - ch_rd is combinational from state, beats_left, fmt_valid and fmt_ready.
//   - ch_rd is never asserted in IDLE.
//   - fmt_data, fmt_first, fmt_last, fmt_chid and fmt_len are stable while fmt_valid && !fmt_ready.
//  Latency and throughput
//   - Eligible in IDLE at cycle c -> ch_rd at c+1 -> fmt_valid=fmt_first=1 at c+2.
//   - With fmt_ready held high: 1 beat/cycle inside a packet.
//   - Last handshake at cycle t -> next fmt_first no earlier than t+3.
//  Boundaries
//   - pkt_len and chnl_en changes during SEND do not affect the current packet; the packet always completes.
//   - Length is latched at grant.
//   - The granted channel's ch_cnt decreasing during SEND is expected.
//   - Count exactly equal to length is eligible.
//   - rr_ptr wraps from CH_NUM-1 to 0.
//   - One channel eligible continuously: it is re-granted every packet.
// TESTING
//  - Reset: rst=1 for 2 cycles with all channels full -> ch_rd=0, fmt_valid=0, busy=0 throughout reset.
//  - Single packet: ch1 en, pkt_len code 0, ch_cnt[1]=4, fmt_ready=1 -> 4 beats with chid=1, len=4; first on beat 0 only, last on beat 3 only; fmt_valid 2 cycles after eligibility.
//  - Round robin: all 4 ch en, code 0, counts 32, ready=1 -> packet order 0,1,2,3,0; each packet 4 beats.
//  - Threshold: ch2 code 1, ch_cnt[2]=7 -> no grant; raise count to 8 -> grant ch2 with 8 beats.
//  - Backpressure: 4-beat packet, fmt_ready low on beats 1 and 3 for 3 cycles each -> outputs held, exactly 4 pops, data order preserved.
//  - Mid-packet changes: clear chnl_en[0] and change pkt_len[0] during a 16-beat packet -> all 16 beats sent; ch0 not re-granted afterwards.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// Packet-level round-robin arbiter between the per-channel slave FIFOs and the MCDF formatter.
// A channel is granted only once its FIFO holds a whole packet; beats then stream out with valid/ready.
module mcdf_arbiter #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        chnl_en,
  input  logic [2*CH_NUM-1:0]      pkt_len,
  input  logic [CH_NUM*CNT_W-1:0]  ch_cnt,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  output logic [CH_NUM-1:0]        ch_rd,
  output logic                     fmt_valid,
  input  logic                     fmt_ready,
  output logic [DATA_W-1:0]        fmt_data,
  output logic                     fmt_first,
  output logic                     fmt_last,
  output logic [CH_W-1:0]          fmt_chid,
  output logic [CNT_W-1:0]         fmt_len,
  output logic                     busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_beats_left;
  logic                r_fmt_valid;
  logic [DATA_W-1:0]   r_fmt_data;
  logic                r_fmt_first;
  logic                r_fmt_last;
  logic [CH_W-1:0]     r_fmt_chid;
  logic [CNT_W-1:0]    r_fmt_len;

  logic [CH_NUM-1:0]   w_elig;
  logic                w_found;
  logic [CH_W-1:0]     w_grant;
  logic [CNT_W-1:0]    w_grant_len;
  int                  w_idx;
  logic                w_load;
  logic                w_done;
  logic [DATA_W-1:0]   w_head_data;

  // Length code 0..3 selects 4, 8, 16 or 32 beats.
  function automatic logic [CNT_W-1:0] len_decode(input logic [1:0] code);
    logic [CNT_W-1:0] base;
    base = CNT_W'(4);
    return base << code;
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_elig[i] = chnl_en[i] &&
                  (ch_cnt[i*CNT_W +: CNT_W] >= len_decode(pkt_len[2*i +: 2]));
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_found     = 1'b0;
    w_grant     = '0;
    w_idx       = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % CH_NUM;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_grant = CH_W'(w_idx);
      end
    end
    w_grant_len = len_decode(pkt_len[2*int'(w_grant) +: 2]);
  end

  assign w_load      = (r_state == SEND) && (r_beats_left != '0) &&
                       (!r_fmt_valid || fmt_ready);
  assign w_done      = (r_state == SEND) && r_fmt_valid && fmt_ready && r_fmt_last;
  assign w_head_data = ch_data[int'(r_fmt_chid)*DATA_W +: DATA_W];

  always_comb begin
    ch_rd = '0;
    if (w_load) begin
      ch_rd[r_fmt_chid] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = SEND;
      SEND:    if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_beats_left <= '0;
      r_fmt_valid  <= 1'b0;
      r_fmt_data   <= '0;
      r_fmt_first  <= 1'b0;
      r_fmt_last   <= 1'b0;
      r_fmt_chid   <= '0;
      r_fmt_len    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_fmt_chid   <= w_grant;
          r_fmt_len    <= w_grant_len;
          r_beats_left <= w_grant_len;
          r_rr_ptr     <= CH_W'((int'(w_grant) + 1) % CH_NUM);
        end
      end else if (w_load) begin
        r_fmt_data   <= w_head_data;
        r_fmt_valid  <= 1'b1;
        r_fmt_first  <= (r_beats_left == r_fmt_len);
        r_fmt_last   <= (r_beats_left == CNT_W'(1));
        r_beats_left <= r_beats_left - CNT_W'(1);
      end else if (w_done) begin
        r_fmt_valid <= 1'b0;
        r_fmt_first <= 1'b0;
        r_fmt_last  <= 1'b0;
      end
    end
  end

  assign fmt_valid = r_fmt_valid;
  assign fmt_data  = r_fmt_data;
  assign fmt_first = r_fmt_first;
  assign fmt_last  = r_fmt_last;
  assign fmt_chid  = r_fmt_chid;
  assign fmt_len   = r_fmt_len;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: a pointer-based FIFO model feeds the channels, stimulus queues
// the hand-computed beats, and a negedge monitor pops and compares every accepted beat.
module tb_mcdf_arbiter;

  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [CH_W-1:0]   chid;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                     clk;
  logic                     rst;
  logic [CH_NUM-1:0]        chnl_en;
  logic [2*CH_NUM-1:0]      pkt_len;
  logic [CH_NUM*CNT_W-1:0]  ch_cnt;
  logic [CH_NUM*DATA_W-1:0] ch_data;
  logic [CH_NUM-1:0]        ch_rd;
  logic                     fmt_valid;
  logic                     fmt_ready;
  logic [DATA_W-1:0]        fmt_data;
  logic                     fmt_first;
  logic                     fmt_last;
  logic [CH_W-1:0]          fmt_chid;
  logic [CNT_W-1:0]         fmt_len;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: word k of channel c holds {A0+c, k}; fill = wr_ptr - rd_ptr.
  logic [31:0] wr_ptr [CH_NUM];
  logic [31:0] rd_ptr [CH_NUM] = '{default: 32'd0};
  logic [31:0] exp_rd [CH_NUM];
  beat_t       sb_q [$];

  mcdf_arbiter #(
    .CH_NUM(CH_NUM), .CH_W(CH_W), .CNT_W(CNT_W), .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .chnl_en   (chnl_en),
    .pkt_len   (pkt_len),
    .ch_cnt    (ch_cnt),
    .ch_data   (ch_data),
    .ch_rd     (ch_rd),
    .fmt_valid (fmt_valid),
    .fmt_ready (fmt_ready),
    .fmt_data  (fmt_data),
    .fmt_first (fmt_first),
    .fmt_last  (fmt_last),
    .fmt_chid  (fmt_chid),
    .fmt_len   (fmt_len),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input int ch, input logic [31:0] k);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(ch);
    return {tag, k[23:0]};
  endfunction

  always_comb begin
    ch_cnt  = '0;
    ch_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      ch_cnt[i*CNT_W +: CNT_W]   = CNT_W'(wr_ptr[i] - rd_ptr[i]);
      ch_data[i*DATA_W +: DATA_W] = word(i, rd_ptr[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_rd[i]) rd_ptr[i] <= rd_ptr[i] + 32'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int ch, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.first = (i == 0);
      b.last  = (i == len - 1);
      b.chid  = CH_W'(ch);
      b.len   = CNT_W'(len);
      b.data  = word(ch, exp_rd[ch] + 32'(i));
      sb_q.push_back(b);
    end
    exp_rd[ch] = exp_rd[ch] + 32'(len);
  endtask

  task automatic set_cnt(input int ch, input int n);
    wr_ptr[ch] = rd_ptr[ch] + 32'(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && !busy) && n < 300) begin
      step();
      n++;
    end
    check(name, 64'(sb_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!fmt_valid && n < 20) begin
      step();
      n++;
    end
    check(name, 64'(fmt_valid), 64'd1);
  endtask

  // Monitor: compares each accepted beat against the scoreboard and checks held outputs under stall.
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    if (!rst) begin
      act = '{first: fmt_first, last: fmt_last, chid: fmt_chid, len: fmt_len, data: fmt_data};
      if (ch_rd != '0) begin
        check("rd_only_in_send", 64'(busy), 64'd1);
        check("rd_onehot", 64'($onehot(ch_rd)), 64'd1);
      end
      if (fmt_valid && prev_stall) check("stall_hold", 64'(act), 64'(prev_beat));
      if (fmt_valid && !fmt_ready) check("stall_no_pop", 64'(ch_rd), 64'd0);
      if (fmt_valid && fmt_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'(act), 64'd0);
        end else begin
          exp = sb_q.pop_front();
          check("beat", 64'(act), 64'(exp));
        end
      end
      prev_stall = fmt_valid && !fmt_ready;
      prev_beat  = act;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CH_NUM; i++) begin
      wr_ptr[i] = 32'd32;
      exp_rd[i] = 32'd0;
    end
    rst       = 1'b1;
    chnl_en   = '1;
    pkt_len   = '0;
    fmt_ready = 1'b1;

    // Reset with every channel full and enabled: nothing may move.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ch_rd", 64'(ch_rd), 64'd0);
      check("rst_valid", 64'(fmt_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    chnl_en = '0;
    rst     = 1'b0;
    step();
    check("idle_no_grant", 64'(busy), 64'd0);

    // Single 4-beat packet on ch1; check grant-to-valid latency.
    set_cnt(1, 4);
    push_pkt(1, 4);
    chnl_en = 4'b0010;
    step();
    check("lat_ch_rd", 64'(ch_rd), 64'b0010);
    check("lat_no_valid_yet", 64'(fmt_valid), 64'd0);
    step();
    check("lat_valid_first", 64'({fmt_valid, fmt_first}), 64'b11);
    wait_drain("single_drain");
    chnl_en = '0;

    // Round robin from a fresh pointer: 0,1,2,3 then wrap to 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < CH_NUM; i++) set_cnt(i, 32);
    pkt_len = '0;
    push_pkt(0, 4);
    push_pkt(1, 4);
    push_pkt(2, 4);
    push_pkt(3, 4);
    push_pkt(0, 4);
    chnl_en = 4'b1111;
    begin
      int n;
      n = 0;
      while (sb_q.size() > 3 && n < 200) begin
        step();
        n++;
      end
      check("rr_reach_last_pkt", 64'(sb_q.size() <= 3), 64'd1);
    end
    chnl_en = '0;
    wait_drain("rr_drain");

    // Threshold: 7 words for an 8-beat packet is not enough; exactly 8 is.
    pkt_len = 8'b00_01_00_00;
    set_cnt(2, 7);
    chnl_en = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      check("thresh_no_grant", 64'({busy, ch_rd}), 64'd0);
    end
    set_cnt(2, 8);
    push_pkt(2, 8);
    wait_drain("thresh_drain");
    chnl_en = '0;

    // Backpressure on beats 1 and 3, three cycles each.
    pkt_len = '0;
    set_cnt(3, 4);
    push_pkt(3, 4);
    chnl_en = 4'b1000;
    wait_valid("bp_first_valid");
    step();
    fmt_ready = 1'b0;
    repeat (3) step();
    fmt_ready = 1'b1;
    step();
    step();
    fmt_ready = 1'b0;
    repeat (3) step();
    fmt_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_pops", 64'(rd_ptr[3]), 64'(exp_rd[3]));
    chnl_en = '0;

    // Disable ch0 and change its length mid-packet: the 16-beat packet still completes.
    pkt_len = 8'b00_00_00_10;
    set_cnt(0, 32);
    push_pkt(0, 16);
    chnl_en = 4'b0001;
    wait_valid("mid_first_valid");
    step();
    step();
    chnl_en = '0;
    pkt_len = '0;
    wait_drain("mid_drain");
    for (int c = 0; c < 5; c++) begin
      step();
      check("mid_no_regrant", 64'({busy, ch_rd}), 64'd0);
    end

    for (int i = 0; i < CH_NUM; i++) check("final_pops", 64'(rd_ptr[i]), 64'(exp_rd[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
